// File: rtl/jtag_shift_sequencer.sv
// Splits an arbitrary-length JTAG scan (1..2^C_LEN_WIDTH-1 bits) into <=32-bit
// engine chunks, streaming TDI words in and captured TDO words out.
module jtag_shift_sequencer #(
    parameter int C_LEN_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET_N,
    input  logic                   CMD_VALID,
    output logic                   CMD_READY,
    input  logic [C_LEN_WIDTH-1:0] CMD_LENGTH,
    input  logic                   CMD_TMS_EXIT,
    input  logic                   TDI_VALID,
    output logic                   TDI_READY,
    input  logic [31:0]            TDI_DATA,
    output logic                   TDO_VALID,
    input  logic                   TDO_READY,
    output logic [31:0]            TDO_DATA,
    output logic                   BUSY,
    output logic                   OP_DONE,
    input  logic                   ABORT,
    output logic                   ENG_ENABLE,
    input  logic                   ENG_DONE,
    output logic [31:0]            ENG_LENGTH,
    output logic [31:0]            ENG_TMS_VECTOR,
    output logic [31:0]            ENG_TDI_VECTOR,
    input  logic [31:0]            ENG_TDO_VECTOR
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, PUSH} state_t;

    state_t                 state;
    logic [C_LEN_WIDTH-1:0] remaining;
    logic                   exit_flag;
    logic                   abort_flag;
    logic [5:0]             chunk;
    logic [5:0]             load_chunk;
    logic                   last_chunk;

    function automatic logic [31:0] chunk_mask(input logic [5:0] n);
        return (n >= 6'd32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    assign load_chunk = (remaining >= C_LEN_WIDTH'(32)) ? 6'd32 : remaining[5:0];
    assign last_chunk = (remaining <= C_LEN_WIDTH'(32));
    assign ENG_LENGTH = 32'(chunk);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        // NOTE: asynchronous reset drops ENG_ENABLE immediately, even mid-chunk.
        if (!RESET_N) begin
            state          <= IDLE;
            remaining      <= '0;
            exit_flag      <= 1'b0;
            abort_flag     <= 1'b0;
            chunk          <= '0;
            CMD_READY      <= 1'b0;
            TDI_READY      <= 1'b0;
            TDO_VALID      <= 1'b0;
            TDO_DATA       <= '0;
            BUSY           <= 1'b0;
            OP_DONE        <= 1'b0;
            ENG_ENABLE     <= 1'b0;
            ENG_TMS_VECTOR <= '0;
            ENG_TDI_VECTOR <= '0;
        end else begin
            OP_DONE <= 1'b0;
            case (state)
                IDLE: begin
                    CMD_READY <= 1'b1;
                    if (CMD_VALID && CMD_READY) begin
                        remaining  <= CMD_LENGTH;
                        exit_flag  <= CMD_TMS_EXIT;
                        abort_flag <= 1'b0;
                        if (CMD_LENGTH == '0) begin
                            OP_DONE <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            CMD_READY <= 1'b0;
                            BUSY      <= 1'b1;
                            TDI_READY <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    // ABORT blocks the handshake: the word on TDI_DATA is not consumed.
                    if (ABORT) begin
                        state     <= IDLE;
                        TDI_READY <= 1'b0;
                        BUSY      <= 1'b0;
                        OP_DONE   <= 1'b1;
                        CMD_READY <= 1'b1;
                    end else if (TDI_VALID) begin
                        chunk          <= load_chunk;
                        ENG_TDI_VECTOR <= TDI_DATA & chunk_mask(load_chunk);
                        ENG_TMS_VECTOR <= (exit_flag && last_chunk) ?
                                          (32'h1 << (load_chunk - 6'd1)) : 32'h0;
                        TDI_READY      <= 1'b0;
                        ENG_ENABLE     <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (ABORT) abort_flag <= 1'b1;
                    if (ENG_DONE) begin
                        ENG_ENABLE <= 1'b0;
                        TDO_DATA   <= ENG_TDO_VECTOR & chunk_mask(chunk);
                        TDO_VALID  <= 1'b1;
                        remaining  <= remaining - C_LEN_WIDTH'(chunk);
                        state      <= PUSH;
                    end
                end
                PUSH: begin
                    if (ABORT) abort_flag <= 1'b1;
                    if (TDO_READY) begin
                        TDO_VALID <= 1'b0;
                        // An ABORT arriving with TDO_READY still ends the operation.
                        if (remaining == '0 || abort_flag || ABORT) begin
                            state     <= IDLE;
                            BUSY      <= 1'b0;
                            OP_DONE   <= 1'b1;
                            CMD_READY <= 1'b1;
                        end else begin
                            state     <= LOAD;
                            TDI_READY <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_shift_sequencer.sv
// Randomized scoreboard bench for jtag_shift_sequencer with a behavioural
// JTAG engine model that returns TDI ^ 0x5A5A5A5A after a random latency.
module tb_jtag_shift_sequencer;

    localparam int LW = 16;
    localparam logic [31:0] SCRAMBLE = 32'h5A5A_5A5A;

    logic          CLK = 1'b0;
    logic          RESET_N = 1'b0;
    logic          CMD_VALID = 1'b0;
    logic          CMD_READY;
    logic [LW-1:0] CMD_LENGTH = '0;
    logic          CMD_TMS_EXIT = 1'b0;
    logic          TDI_VALID = 1'b0;
    logic          TDI_READY;
    logic [31:0]   TDI_DATA = '0;
    logic          TDO_VALID;
    logic          TDO_READY = 1'b0;
    logic [31:0]   TDO_DATA;
    logic          BUSY;
    logic          OP_DONE;
    logic          ABORT = 1'b0;
    logic          ENG_ENABLE;
    logic          ENG_DONE;
    logic [31:0]   ENG_LENGTH;
    logic [31:0]   ENG_TMS_VECTOR;
    logic [31:0]   ENG_TDI_VECTOR;
    logic [31:0]   ENG_TDO_VECTOR = '0;
    logic          eng_done_m = 1'b0;
    logic          eng_done_spur = 1'b0;

    assign ENG_DONE = eng_done_m | eng_done_spur;

    jtag_shift_sequencer #(.C_LEN_WIDTH(LW)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
        .CMD_LENGTH(CMD_LENGTH), .CMD_TMS_EXIT(CMD_TMS_EXIT),
        .TDI_VALID(TDI_VALID), .TDI_READY(TDI_READY), .TDI_DATA(TDI_DATA),
        .TDO_VALID(TDO_VALID), .TDO_READY(TDO_READY), .TDO_DATA(TDO_DATA),
        .BUSY(BUSY), .OP_DONE(OP_DONE), .ABORT(ABORT),
        .ENG_ENABLE(ENG_ENABLE), .ENG_DONE(ENG_DONE), .ENG_LENGTH(ENG_LENGTH),
        .ENG_TMS_VECTOR(ENG_TMS_VECTOR), .ENG_TDI_VECTOR(ENG_TDI_VECTOR),
        .ENG_TDO_VECTOR(ENG_TDO_VECTOR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] len;
        logic [31:0] tms;
        logic [31:0] tdi;
    } chunk_t;

    chunk_t      chunk_q[$];
    logic [31:0] tdo_q[$];

    int checks = 0;
    int errors = 0;
    int eng_rises = 0;
    int op_done_cnt = 0;
    int tdi_cnt = 0;
    bit stall_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mask_of(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    endfunction

    // Engine model: checks each chunk on ENABLE rise, answers after 1..4 cycles.
    initial begin : engine
        logic   prev;
        chunk_t seen;
        chunk_t e;
        int     lat;
        bit     aborted;
        prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (ENG_ENABLE && !prev) begin
                eng_rises++;
                seen = '{ENG_LENGTH, ENG_TMS_VECTOR, ENG_TDI_VECTOR};
                if (chunk_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_chunk: engine started with length %0d, none expected", ENG_LENGTH);
                end else begin
                    e = chunk_q.pop_front();
                    check("eng_length", seen.len, e.len);
                    check("eng_tms", seen.tms, e.tms);
                    check("eng_tdi", seen.tdi, e.tdi);
                end
                lat = $urandom_range(1, 4);
                aborted = 0;
                for (int i = 0; i < lat; i++) begin
                    @(posedge CLK);
                    if (!RESET_N) aborted = 1;
                end
                #1;
                if (!aborted && RESET_N) begin
                    check("eng_enable_held", ENG_ENABLE, 1'b1);
                    check("eng_tdi_stable", ENG_TDI_VECTOR, seen.tdi);
                    ENG_TDO_VECTOR = ENG_TDI_VECTOR ^ SCRAMBLE;
                    eng_done_m = 1'b1;
                    tick();
                    eng_done_m = 1'b0;
                    ENG_TDO_VECTOR = $urandom();
                end
            end
            prev = ENG_ENABLE;
        end
    end

    // TDO monitor: pops the scoreboard on every accepted word, checks hold stability.
    logic [31:0] hold_data;
    bit          hold_pending = 0;
    always @(negedge CLK) begin
        if (!RESET_N) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) begin
                check("tdo_valid_held", TDO_VALID, 1'b1);
                check("tdo_data_held", TDO_DATA, hold_data);
            end
            hold_pending = 0;
            if (TDO_VALID) begin
                if (TDO_READY) begin
                    if (tdo_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_tdo: got 0x%0h with no word expected", TDO_DATA);
                    end else begin
                        check("tdo_data", TDO_DATA, tdo_q.pop_front());
                    end
                end else begin
                    hold_pending = 1;
                    hold_data = TDO_DATA;
                end
            end
        end
    end

    logic prev_od = 1'b0;
    always @(negedge CLK) begin
        if (OP_DONE) begin
            op_done_cnt++;
            check("op_done_single_cycle", prev_od, 1'b0);
        end
        prev_od = OP_DONE;
        if (TDI_VALID && TDI_READY && !ABORT) tdi_cnt++;
    end

    // TDO consumer: random back-pressure, or a forced 10-cycle stall.
    initial begin : tdo_sink
        int r0;
        forever begin
            tick();
            if (stall_mode && TDO_VALID) begin
                TDO_READY = 1'b0;
                r0 = eng_rises;
                for (int i = 0; i < 10; i++) begin
                    tick();
                    check("stall_no_new_chunk", eng_rises, r0);
                end
                stall_mode = 0;
                TDO_READY = 1'b1;
            end else begin
                TDO_READY = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // abort_kind: 0 none, 1 abort in first LOAD (with TDI_VALID), 2 abort in first RUN.
    task automatic run_op(input int len, input bit ex, input int abort_kind,
                          input bit fixed, input logic [31:0] fw);
        int          nw, nexp, od0, td0, n, c;
        logic [31:0] w;
        logic [31:0] words[$];
        nw = (len + 31) / 32;
        nexp = (abort_kind == 1) ? 0 : (abort_kind == 2) ? ((nw > 0) ? 1 : 0) : nw;
        for (int k = 0; k < nexp; k++) begin
            w = fixed ? fw : $urandom();
            words.push_back(w);
            c = (len - 32 * k > 32) ? 32 : len - 32 * k;
            chunk_q.push_back('{32'(c),
                               (ex && k == nw - 1) ? (32'h1 << (c - 1)) : 32'h0,
                               w & mask_of(c)});
            tdo_q.push_back((w ^ SCRAMBLE) & mask_of(c));
        end
        od0 = op_done_cnt;
        td0 = tdi_cnt;

        n = 0;
        while (!CMD_READY && n < 100) begin tick(); n++; end
        check("cmd_ready_idle", CMD_READY, 1'b1);
        CMD_VALID = 1'b1;
        CMD_LENGTH = LW'(len);
        CMD_TMS_EXIT = ex;
        tick();
        CMD_VALID = 1'b0;
        check("busy_after_accept", BUSY, len != 0);
        check("op_done_after_accept", OP_DONE, len == 0);

        if (len == 0) begin
            check("tdi_ready_zero_len", TDI_READY, 1'b0);
            check("cmd_ready_zero_len", CMD_READY, 1'b1);
        end else if (abort_kind == 1) begin
            check("tdi_ready_in_load", TDI_READY, 1'b1);
            TDI_VALID = 1'b1;
            TDI_DATA = $urandom();
            ABORT = 1'b1;
            tick();
            ABORT = 1'b0;
            TDI_VALID = 1'b0;
            check("op_done_load_abort", OP_DONE, 1'b1);
            check("busy_load_abort", BUSY, 1'b0);
        end else begin
            for (int k = 0; k < nexp; k++) begin
                TDI_VALID = 1'b1;
                TDI_DATA = words[k];
                n = 0;
                while (!TDI_READY && n < 500) begin tick(); n++; end
                check("tdi_handshake_in_time", n < 500, 1'b1);
                tick();
                TDI_VALID = 1'b0;
                if (abort_kind == 2 && k == 0) begin
                    ABORT = 1'b1;
                    tick();
                    ABORT = 1'b0;
                end
            end
        end

        n = 0;
        while (op_done_cnt == od0 && n < 2000) begin tick(); n++; end
        tick();
        tick();
        check("op_done_count", op_done_cnt - od0, 1);
        check("tdi_words_consumed", tdi_cnt - td0, nexp);
        check("busy_end", BUSY, 1'b0);
        check("chunks_drained", chunk_q.size(), 0);
        check("tdo_drained", tdo_q.size(), 0);
    endtask

    initial begin : stimulus
        int len, r;
        logic [31:0] w;
        #2;
        check("rst_cmd_ready", CMD_READY, 1'b0);
        check("rst_tdi_ready", TDI_READY, 1'b0);
        check("rst_tdo_valid", TDO_VALID, 1'b0);
        check("rst_tdo_data", TDO_DATA, 32'h0);
        check("rst_busy", BUSY, 1'b0);
        check("rst_op_done", OP_DONE, 1'b0);
        check("rst_eng_enable", ENG_ENABLE, 1'b0);
        check("rst_eng_length", ENG_LENGTH, 32'h0);
        check("rst_eng_tms", ENG_TMS_VECTOR, 32'h0);
        check("rst_eng_tdi", ENG_TDI_VECTOR, 32'h0);
        tick();
        RESET_N = 1'b1;
        tick();
        check("cmd_ready_after_reset", CMD_READY, 1'b1);

        run_op(8, 1, 0, 1, 32'h0000_00A5);
        run_op(70, 1, 0, 1, 32'hFFFF_FFFF);
        run_op(0, 1, 0, 0, 32'h0);
        stall_mode = 1;
        run_op(64, 0, 0, 0, 32'h0);
        run_op(96, 0, 2, 0, 32'h0);
        run_op(50, 1, 1, 0, 32'h0);

        // Stray engine completion while idle must be ignored.
        eng_done_spur = 1'b1;
        tick();
        eng_done_spur = 1'b0;
        tick();
        check("spurious_done_tdo_valid", TDO_VALID, 1'b0);
        check("spurious_done_busy", BUSY, 1'b0);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 3))
                0: len = $urandom_range(1, 32);
                1: len = $urandom_range(33, 200);
                2: begin
                    r = $urandom_range(0, 7);
                    len = (r == 0) ? 1 : (r == 1) ? 31 : (r == 2) ? 32 : (r == 3) ? 33 :
                          (r == 4) ? 63 : (r == 5) ? 64 : (r == 6) ? 65 : 96;
                end
                default: len = $urandom_range(1, 1000);
            endcase
            r = $urandom_range(0, 9);
            run_op(len, 1'($urandom_range(0, 1)), (r == 0) ? 1 : (r == 1) ? 2 : 0, 0, 32'h0);
        end
        run_op(65535, 1, 0, 0, 32'h0);

        // Reset while a chunk is running.
        w = $urandom();
        chunk_q.push_back('{32'd32, 32'h0, w});
        CMD_VALID = 1'b1;
        CMD_LENGTH = LW'(40);
        CMD_TMS_EXIT = 1'b0;
        tick();
        CMD_VALID = 1'b0;
        TDI_VALID = 1'b1;
        TDI_DATA = w;
        r = 0;
        while (!ENG_ENABLE && r < 100) begin
            tick();
            if (TDI_READY === 1'b0) TDI_VALID = 1'b0;
            r++;
        end
        TDI_VALID = 1'b0;
        check("reset_test_reached_run", ENG_ENABLE, 1'b1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("async_rst_eng_enable", ENG_ENABLE, 1'b0);
        check("async_rst_busy", BUSY, 1'b0);
        check("async_rst_tdo_valid", TDO_VALID, 1'b0);
        check("async_rst_cmd_ready", CMD_READY, 1'b0);
        tick();
        tick();
        RESET_N = 1'b1;
        tick();
        check("cmd_ready_after_mid_reset", CMD_READY, 1'b1);
        chunk_q.delete();
        tdo_q.delete();
        repeat (8) tick();
        run_op(8, 1, 0, 0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
